// File: rtl/systolic_pkg.sv
// Shared types for the systolic array drain stage: drain FSM states and the default result word.
package systolic_pkg;

  localparam int DEF_WORD_SIZE = 16;

  typedef logic [DEF_WORD_SIZE-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } drain_state_t;

endpackage

// File: rtl/drain_fifo.sv
// drain_fifo: synchronous first-word-fall-through FIFO buffering drained array results.
// DEPTH must be a power of two so the pointers wrap naturally.
module drain_fifo
  import systolic_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = DEF_WORD_SIZE
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_LEVEL);
  assign valid   = (count != '0);
  assign do_pop  = pop & valid;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts a push.
  assign do_push = push & (~full | do_pop);

  // Head is forced to zero while empty so the uninitialised storage never leaks out.
  assign pop_data = valid ? mem[rd_ptr] : '0;
  assign level    = count;

  // NOTE: the storage array has no reset; only pointers and count need a known state,
  // and leaving the RAM unreset lets it map onto plain memory cells.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // NOTE: all clocked state uses non-blocking assignments so every register samples
  // pre-edge values regardless of the order the blocks are evaluated in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && full && !do_pop));

endmodule

// File: rtl/systolic_drain.sv
// systolic_drain: pulses arr_read to shift PE_NUMBER results out of the array into a FWFT FIFO.
// Define SYSTOLIC_DRAIN_AUTOCLR_EN to pulse arr_reset in DONE, clearing the array for the next tile.
module systolic_drain
  import systolic_pkg::*;
#(
  parameter int PE_NUMBER  = 64,
  parameter int WORD_SIZE  = DEF_WORD_SIZE,
  parameter int FIFO_DEPTH = 16,
  parameter int READ_LAT   = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  output logic                          arr_read,
  output logic                          arr_reset,
  input  logic [WORD_SIZE-1:0]          arr_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WORD_SIZE-1:0]          out_data,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int CW = $clog2(PE_NUMBER) + 1;
  localparam logic [CW-1:0] PE_CNT  = CW'(PE_NUMBER);
  localparam logic [CW-1:0] PE_LAST = CW'(PE_NUMBER - 1);

  drain_state_t        state;
  drain_state_t        state_nxt;
  logic [CW-1:0]       issued;
  logic [CW-1:0]       captured;
  logic [CW-1:0]       inflight;
  logic [READ_LAT-1:0] vpipe;
  logic                capture;
  logic                credit_ok;

  assign inflight  = issued - captured;
  // Reads already in flight reserve their FIFO slot, so a landing word always has room.
  assign credit_ok = (int'(level) + int'(inflight)) < FIFO_DEPTH;
  assign arr_read  = (state == DRAIN) && (issued < PE_CNT) && credit_ok;
  assign capture   = vpipe[READ_LAT-1];
  assign busy      = (state != IDLE);

`ifdef SYSTOLIC_DRAIN_AUTOCLR_EN
  assign arr_reset = (state == DONE);
`else
  assign arr_reset = 1'b0;
`endif

  // NOTE: state_nxt gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = DRAIN;
      DRAIN:   if (issued == PE_CNT) state_nxt = FLUSH;
      FLUSH:   if (captured == PE_CNT) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      issued   <= '0;
      captured <= '0;
      vpipe    <= '0;
      done     <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= capture && (captured == PE_LAST);

      vpipe[0] <= arr_read;
      for (int i = 1; i < READ_LAT; i++) begin
        vpipe[i] <= vpipe[i-1];
      end

      // Counters keep the previous tile's totals until the next accepted start.
      if (state == IDLE && start) begin
        issued   <= '0;
        captured <= '0;
      end else begin
        if (arr_read) issued   <= issued + 1'b1;
        if (capture)  captured <= captured + 1'b1;
      end
    end
  end

  drain_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WORD_SIZE)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (capture),
    .push_data (arr_data),
    .pop       (out_ready),
    .pop_data  (out_data),
    .valid     (out_valid),
    .level     (level)
  );

  a_credit: assert property (@(posedge clk) disable iff (reset)
    (int'(level) + int'(inflight)) <= FIFO_DEPTH);

  a_capture_order: assert property (@(posedge clk) disable iff (reset)
    captured <= issued);

endmodule

// File: tb/tb_systolic_drain.sv
// tb_systolic_drain: two drain instances (shallow/long-latency and deep/short-latency) driven by
// a behavioural array model; delivered words are compared against the words the array emitted.
module tb_systolic_drain;

  localparam int W   = 16;
  localparam int PE0 = 4;
  localparam int D0  = 16;
  localparam int L0  = 1;
  localparam int PE1 = 8;
  localparam int D1  = 4;
  localparam int L1  = 3;
`ifdef SYSTOLIC_DRAIN_AUTOCLR_EN
  localparam int CLR_EXP = 1;
`else
  localparam int CLR_EXP = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic           start_s     [2];
  logic           arr_read_s  [2];
  logic           arr_reset_s [2];
  logic [W-1:0]   arr_data_s  [2];
  logic           out_valid_s [2];
  logic           out_ready_s [2];
  logic [W-1:0]   out_data_s  [2];
  logic           busy_s      [2];
  logic           done_s      [2];
  logic [$clog2(D0):0] level0;
  logic [$clog2(D1):0] level1;
  int             level_i     [2];

  always_comb begin
    level_i[0] = int'(level0);
    level_i[1] = int'(level1);
  end

  systolic_drain #(.PE_NUMBER(PE0), .WORD_SIZE(W), .FIFO_DEPTH(D0), .READ_LAT(L0)) dut0 (
    .clk(clk), .reset(reset), .start(start_s[0]), .arr_read(arr_read_s[0]),
    .arr_reset(arr_reset_s[0]), .arr_data(arr_data_s[0]), .out_valid(out_valid_s[0]),
    .out_ready(out_ready_s[0]), .out_data(out_data_s[0]), .busy(busy_s[0]),
    .done(done_s[0]), .level(level0)
  );

  systolic_drain #(.PE_NUMBER(PE1), .WORD_SIZE(W), .FIFO_DEPTH(D1), .READ_LAT(L1)) dut1 (
    .clk(clk), .reset(reset), .start(start_s[1]), .arr_read(arr_read_s[1]),
    .arr_reset(arr_reset_s[1]), .arr_data(arr_data_s[1]), .out_valid(out_valid_s[1]),
    .out_ready(out_ready_s[1]), .out_data(out_data_s[1]), .busy(busy_s[1]),
    .done(done_s[1]), .level(level1)
  );

  int pe_n  [2] = '{PE0, PE1};
  int lat_n [2] = '{L0, L1};
  int dep_n [2] = '{D0, D1};

  // Array model state: preset words, words emitted in read order, words delivered downstream.
  logic [W-1:0] src_q [2][$];
  logic [W-1:0] exp_q [2][$];
  logic [W-1:0] rx_q  [2][$];
  int           due_q [2][$];
  logic [W-1:0] pw_q  [2][$];
  bit           landing [2];

  int cyc = 0;
  int reads [2], dones [2], clrs [2], run [2], max_run [2], credit_bad [2];

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Array: a read seen during cycle c presents its word on arr_data during cycle c+READ_LAT;
  // every other cycle carries junk so mistimed captures are visible.
  initial begin
    logic [W-1:0] w;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      for (int d = 0; d < 2; d++) begin
        landing[d] = 1'b0;
        if (reset) begin
          due_q[d].delete();
          pw_q[d].delete();
          arr_data_s[d] = '0;
        end else begin
          if (due_q[d].size() > 0 && due_q[d][0] == cyc) begin
            arr_data_s[d] = pw_q[d].pop_front();
            void'(due_q[d].pop_front());
            landing[d] = 1'b1;
          end else begin
            arr_data_s[d] = W'($urandom);
          end
          if (arr_read_s[d]) begin
            w = (src_q[d].size() > 0) ? src_q[d].pop_front() : W'($urandom);
            exp_q[d].push_back(w);
            due_q[d].push_back(cyc + lat_n[d]);
            pw_q[d].push_back(w);
          end
        end
      end
    end
  end

  // Observation on the falling edge, where every DUT output is settled.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!reset) begin
        if (arr_read_s[d]) begin
          reads[d]++;
          run[d]++;
          if (run[d] > max_run[d]) max_run[d] = run[d];
        end else begin
          run[d] = 0;
        end
        if (done_s[d]) dones[d]++;
        if (arr_reset_s[d]) clrs[d]++;
        if (out_valid_s[d] && out_ready_s[d]) rx_q[d].push_back(out_data_s[d]);
        if (level_i[d] + due_q[d].size() + int'(landing[d]) > dep_n[d]) credit_bad[d]++;
      end
    end
  end

  task automatic clear_model(input int d);
    src_q[d].delete();
    exp_q[d].delete();
    rx_q[d].delete();
    reads[d] = 0;
    dones[d] = 0;
    clrs[d] = 0;
    run[d] = 0;
    max_run[d] = 0;
    credit_bad[d] = 0;
  endtask

  task automatic pulse_start(input int d);
    start_s[d] = 1'b1;
    tick();
    start_s[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d, input int budget, input string tag);
    int n = 0;
    while ((busy_s[d] || out_valid_s[d]) && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_timeout"}, n < budget, 1);
  endtask

  task automatic check_stream(input int d, input string tag);
    int bad = 0;
    check({tag, "_rx_count"}, rx_q[d].size(), pe_n[d]);
    check({tag, "_arr_words"}, exp_q[d].size(), pe_n[d]);
    for (int i = 0; i < rx_q[d].size() && i < exp_q[d].size(); i++) begin
      if (rx_q[d][i] !== exp_q[d][i]) bad++;
    end
    check({tag, "_order"}, bad, 0);
  endtask

  task automatic check_reset_outputs(input int d, input string tag);
    check({tag, "_busy"},      busy_s[d],      0);
    check({tag, "_arr_read"},  arr_read_s[d],  0);
    check({tag, "_arr_reset"}, arr_reset_s[d], 0);
    check({tag, "_done"},      done_s[d],      0);
    check({tag, "_out_valid"}, out_valid_s[d], 0);
    check({tag, "_out_data"},  out_data_s[d],  0);
    check({tag, "_level"},     level_i[d],     0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    bit prev_done;
    for (int d = 0; d < 2; d++) begin
      start_s[d]     = 1'b0;
      out_ready_s[d] = 1'b0;
      arr_data_s[d]  = '0;
      clear_model(d);
    end

    reset = 1'b1;
    repeat (3) tick();
    check_reset_outputs(0, "rst0");
    check_reset_outputs(1, "rst1");
    reset = 1'b0;
    tick();

    // Deep FIFO, unit latency, consumer always ready: four back-to-back reads.
    clear_model(0);
    src_q[0].push_back(16'd10);
    src_q[0].push_back(16'd20);
    src_q[0].push_back(16'd30);
    src_q[0].push_back(16'd40);
    out_ready_s[0] = 1'b1;
    pulse_start(0);
    wait_idle(0, 200, "t1");
    tick();
    check("t1_reads", reads[0], 4);
    check("t1_read_run", max_run[0], 4);
    check("t1_done_pulses", dones[0], 1);
    check("t1_arr_reset_pulses", clrs[0], CLR_EXP);
    for (int i = 0; i < 4; i++) begin
      check("t1_word", (i < rx_q[0].size()) ? int'(rx_q[0][i]) : -1, 10 * (i + 1));
    end

    // Shallow FIFO, long latency, consumer stalled: credit must stop issue at FIFO_DEPTH.
    clear_model(1);
    out_ready_s[1] = 1'b0;
    pulse_start(1);
    repeat (40) tick();
    check("t2_stalled_reads", reads[1], D1);
    check("t2_stalled_level", level_i[1], D1);
    check("t2_stalled_busy", busy_s[1], 1);
    check("t2_stalled_arr_read", arr_read_s[1], 0);
    out_ready_s[1] = 1'b1;
    wait_idle(1, 400, "t2");
    tick();
    check("t2_reads", reads[1], PE1);
    check("t2_done_pulses", dones[1], 1);
    check("t2_credit", credit_bad[1], 0);
    check_stream(1, "t2");

    // Toggling consumer; extra start pulses while draining and during DONE are ignored.
    clear_model(1);
    out_ready_s[1] = 1'b1;
    pulse_start(1);
    prev_done = 1'b0;
    n = 0;
    while (n < 600) begin
      start_s[1] = (n == 5) || prev_done;
      prev_done  = done_s[1];
      if (!busy_s[1] && !out_valid_s[1] && !start_s[1]) break;
      out_ready_s[1] = ~out_ready_s[1];
      tick();
      n++;
    end
    start_s[1] = 1'b0;
    check("t3_timeout", n < 600, 1);
    out_ready_s[1] = 1'b1;
    repeat (6) tick();
    check("t3_idle_after", busy_s[1], 0);
    check("t3_reads", reads[1], PE1);
    check("t3_done_pulses", dones[1], 1);
    check("t3_arr_reset_pulses", clrs[1], CLR_EXP);
    check("t3_credit", credit_bad[1], 0);
    check_stream(1, "t3");

    // Reset part-way through a tile, then a clean full drain.
    clear_model(0);
    out_ready_s[0] = 1'b0;
    pulse_start(0);
    n = 0;
    while (level_i[0] < 2 && n < 50) begin
      tick();
      n++;
    end
    check("t4_partial_timeout", n < 50, 1);
    check("t4_partial_level", level_i[0], 2);
    reset = 1'b1;
    #1;
    check_reset_outputs(0, "t4_rst");
    repeat (2) tick();
    reset = 1'b0;
    tick();
    clear_model(0);
    out_ready_s[0] = 1'b1;
    pulse_start(0);
    wait_idle(0, 200, "t4");
    tick();
    check("t4_reads", reads[0], PE0);
    check("t4_done_pulses", dones[0], 1);
    check_stream(0, "t4");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
